// File: rtl/gf180mcu_fd_sc_mcu9t5v0__dlyline_prog.sv
// Programmable clocked delay line: delays I by 0..MAX_DEPTH enabled cycles with a tap-valid flag.
// Optional macro DLYLINE_ZMASK_EN forces Z to zero whenever ZV is low.
module gf180mcu_fd_sc_mcu9t5v0__dlyline_prog #(
    parameter  int WIDTH     = 1,
    parameter  int MAX_DEPTH = 8,
    localparam int SELW      = $clog2(MAX_DEPTH + 1)
) (
    input  logic             CLK,
    input  logic             RN,
    input  logic             EN,
    input  logic             FLUSH,
    input  logic [WIDTH-1:0] I,
    input  logic [SELW-1:0]  SEL,
    output logic [WIDTH-1:0] Z,
    output logic             ZV
);

    localparam logic [SELW-1:0] DEPTH_C = SELW'(MAX_DEPTH);

    logic [WIDTH-1:0] stage_q [1:MAX_DEPTH];
    logic [WIDTH-1:0] stage_d [1:MAX_DEPTH];
    // tap[0] is the combinational bypass; tap[k] is stage k.
    logic [WIDTH-1:0] tap     [0:MAX_DEPTH];
    logic [SELW-1:0]  sel_q, sel_d;
    logic [SELW-1:0]  hist_q, hist_d;
    logic [WIDTH-1:0] z_raw;

    assign tap[0] = I;

    genvar gi;
    generate
        for (gi = 1; gi <= MAX_DEPTH; gi++) begin : g_stage
            always_comb begin
                stage_d[gi] = stage_q[gi];
                if (FLUSH) begin
                    stage_d[gi] = '0;
                end else if (EN) begin
                    stage_d[gi] = tap[gi-1];
                end
            end

            always_ff @(posedge CLK or negedge RN) begin
                if (!RN) begin
                    stage_q[gi] <= '0;
                end else begin
                    stage_q[gi] <= stage_d[gi];
                end
            end

            assign tap[gi] = stage_q[gi];
        end
    endgenerate

    // Out-of-range requests behave as the deepest tap, so the mux index stays legal.
    always_comb begin
        sel_d = SEL;
        if (SEL > DEPTH_C) begin
            sel_d = DEPTH_C;
        end
    end

    always_comb begin
        hist_d = hist_q;
        if (FLUSH) begin
            hist_d = '0;
        end else if (EN && (hist_q != DEPTH_C)) begin
            hist_d = hist_q + 1'b1;
        end
    end

    always_ff @(posedge CLK or negedge RN) begin
        if (!RN) begin
            sel_q  <= '0;
            hist_q <= '0;
        end else begin
            sel_q  <= sel_d;
            hist_q <= hist_d;
        end
    end

    assign z_raw = tap[sel_q];
    assign ZV    = (hist_q >= sel_q);

`ifdef DLYLINE_ZMASK_EN
    assign Z = ZV ? z_raw : '0;
`else
    assign Z = z_raw;
`endif

endmodule

// File: tb/tb_gf180mcu_fd_sc_mcu9t5v0__dlyline_prog.sv
// Randomized bench for the programmable delay line, checked against a queue-based history model.
module tb_gf180mcu_fd_sc_mcu9t5v0__dlyline_prog;

    localparam int W  = 4;
    localparam int D  = 8;
    localparam int SW = 4;

    logic          CLK = 1'b0;
    logic          RN;
    logic          EN;
    logic          FLUSH;
    logic [W-1:0]  I;
    logic [SW-1:0] SEL;
    logic [W-1:0]  Z;
    logic          ZV;

    int total = 0;
    int bad   = 0;

    // Model: enabled-edge inputs since the last clear, newest first, capped at D entries.
    logic [W-1:0] m_q[$];
    int           m_sel;

    gf180mcu_fd_sc_mcu9t5v0__dlyline_prog #(.WIDTH(W), .MAX_DEPTH(D)) dut (
        .CLK  (CLK),
        .RN   (RN),
        .EN   (EN),
        .FLUSH(FLUSH),
        .I    (I),
        .SEL  (SEL),
        .Z    (Z),
        .ZV   (ZV)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input int obs, input int exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic int exp_zv();
        return (m_q.size() >= m_sel) ? 1 : 0;
    endfunction

    function automatic int exp_z();
        int raw;
        if (m_sel == 0)              raw = int'(I);
        else if (m_sel <= m_q.size()) raw = int'(m_q[m_sel-1]);
        else                          raw = 0;
`ifdef DLYLINE_ZMASK_EN
        if (exp_zv() == 0) raw = 0;
`endif
        return raw;
    endfunction

    task automatic check_out(input string tag);
        chk({tag, ".ZV"}, int'(ZV), exp_zv());
        chk({tag, ".Z"}, int'(Z), exp_z());
        $display("txn %-8s en=%0b fl=%0b i=%h sel=%0d -> z=%h zv=%0b", tag, EN, FLUSH, I, SEL, Z, ZV);
    endtask

    // One clock: present inputs, let the edge happen, advance the model, then check.
    task automatic cyc(input string tag, input logic en, input logic fl,
                       input logic [W-1:0] din, input logic [SW-1:0] sel);
        EN = en; FLUSH = fl; I = din; SEL = sel;
        @(posedge CLK);
        m_sel = (int'(sel) > D) ? D : int'(sel);
        if (fl) begin
            m_q.delete();
        end else if (en) begin
            m_q.push_front(din);
            if (m_q.size() > D) void'(m_q.pop_back());
        end
        #1;
        check_out(tag);
    endtask

    task automatic async_reset(input string tag);
        RN = 1'b0;
        m_q.delete();
        m_sel = 0;
        #1;
        check_out(tag);
        RN = 1'b1;
    endtask

    initial begin
        RN = 1'b0; EN = 1'b0; FLUSH = 1'b0; I = 4'h1; SEL = '0;
        m_sel = 0;
        #2;
        check_out("rst");
        @(posedge CLK); #2;
        I = 4'h7; SEL = 4'd5; #1;
        check_out("rst_byp");
        @(negedge CLK);
        RN = 1'b1;

        cyc("byp", 1'b0, 1'b0, 4'h1, 4'd0);

        // Fill latency with SEL=3 and an incrementing data sequence.
        for (int k = 1; k <= 6; k++) cyc("fill", 1'b1, 1'b0, 4'(k), 4'd3);

        // Enable gating with SEL=2.
        cyc("fl_clr", 1'b0, 1'b1, 4'h0, 4'd2);
        cyc("gate", 1'b1, 1'b0, 4'hA, 4'd2);
        cyc("gate", 1'b0, 1'b0, 4'hB, 4'd2);
        cyc("gate", 1'b1, 1'b0, 4'hC, 4'd2);

        // Fill to saturation, raise SEL 3->6, then flush.
        for (int k = 0; k < 8; k++) cyc("sat", 1'b1, 1'b0, 4'($urandom), 4'd3);
        cyc("sel6", 1'b1, 1'b0, 4'h5, 4'd6);
        cyc("flush", 1'b1, 1'b1, 4'h9, 4'd6);
        for (int k = 0; k < 7; k++) cyc("refill", 1'b1, 1'b0, 4'($urandom), 4'd6);

        // Clamp: SEL=15 behaves as 8.
        for (int k = 0; k < 20; k++) cyc("clamp", 1'b1, 1'b0, 4'($urandom), 4'd15);

        // Asynchronous reset mid-run with SEL=5.
        cyc("pre_rst", 1'b1, 1'b0, 4'h3, 4'd5);
        async_reset("arst");
        cyc("post_rst", 1'b1, 1'b0, 4'h6, 4'd5);

        // Randomized traffic.
        for (int n = 0; n < 400; n++) begin
            cyc("rnd", ($urandom_range(0, 3) != 0), ($urandom_range(0, 19) == 0),
                4'($urandom), 4'($urandom));
            if ($urandom_range(0, 49) == 0) async_reset("rnd_rst");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
